operand_fetch_stage: RTL

Issue-side operand fetch stage for the CPU24 datapath, sitting directly upstream of the execute stage and driving the read ports of `RegFileUnit`. It accepts one decoded instruction per cycle and reads both source registers. Writeback data arriving in the same cycle is bypassed, and a per-register pending scoreboard stalls RAW/WAW hazards. Operands are registered toward execute behind a valid/ready handshake.

---
 rtl/cpu24_pkg.sv | 12 +
 rtl/reg_scoreboard.sv | 56 +++++
 rtl/operand_fetch_stage.sv | 100 ++++++++++
 3 files changed

// File: rtl/cpu24_pkg.sv
// Shared CPU24 datapath types and default sizes.
// Imported by the operand fetch stage and its scoreboard.
package cpu24_pkg;

  localparam int WIDTH = 24;
  localparam int SIZE  = 8;
  localparam int AW    = $clog2(SIZE);

  typedef logic [AW-1:0]    regAddr_t;
  typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits with same-cycle writeback visibility.
// Optional feature macro: CPU24_ZERO_REG_EN (r0 never pending).
module reg_scoreboard
  import cpu24_pkg::*;
#(
  parameter int SIZE = cpu24_pkg::SIZE,
  parameter int AW   = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [AW-1:0] addr_d,
  output logic          pend_a,
  output logic          pend_b,
  output logic          pend_d
);

  logic [SIZE-1:0] pending;
  logic [SIZE-1:0] eff;
  logic            set_ok;

`ifdef CPU24_ZERO_REG_EN
  assign set_ok = set_en && (set_addr != '0);
`else
  assign set_ok = set_en;
`endif

  // Pending view with this cycle's writeback already retired
  always_comb begin
    eff = pending;
    if (clr_en) eff[clr_addr] = 1'b0;
`ifdef CPU24_ZERO_REG_EN
    eff[0] = 1'b0;
`endif
  end

  assign pend_a = eff[addr_a];
  assign pend_b = eff[addr_b];
  assign pend_d = eff[addr_d];

  // Clear on writeback, then set on issue so a same-cycle set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      if (clr_en) pending[clr_addr] <= 1'b0;
      if (set_ok) pending[set_addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// CPU24 operand fetch: regfile read, writeback bypass, hazard stall.
// Optional feature macro: CPU24_ZERO_REG_EN (r0 hardwired to zero).
module operand_fetch_stage
  import cpu24_pkg::*;
#(
  parameter int WIDTH = cpu24_pkg::WIDTH,
  parameter int SIZE  = cpu24_pkg::SIZE,
  parameter int AW    = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [AW-1:0]    inRegA,
  input  logic [AW-1:0]    inRegB,
  input  logic [AW-1:0]    inRegD,
  input  logic             inWrEn,
  output logic [AW-1:0]    rdAddrA,
  output logic [AW-1:0]    rdAddrB,
  input  logic [WIDTH-1:0] rdDataA,
  input  logic [WIDTH-1:0] rdDataB,
  input  logic             wbValid,
  input  logic [AW-1:0]    wbAddr,
  input  logic [WIDTH-1:0] wbData,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outOpA,
  output logic [WIDTH-1:0] outOpB,
  output logic [AW-1:0]    outRegD,
  output logic             outWrEn
);

  logic             pend_a;
  logic             pend_b;
  logic             pend_d;
  logic             hazard;
  logic             accept;
  logic             hit_a;
  logic             hit_b;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  assign rdAddrA = inRegA;
  assign rdAddrB = inRegB;

  reg_scoreboard #(
    .SIZE (SIZE),
    .AW   (AW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst),
    .set_en   (accept & inWrEn),
    .set_addr (inRegD),
    .clr_en   (wbValid),
    .clr_addr (wbAddr),
    .addr_a   (inRegA),
    .addr_b   (inRegB),
    .addr_d   (inRegD),
    .pend_a   (pend_a),
    .pend_b   (pend_b),
    .pend_d   (pend_d)
  );

  assign hazard  = pend_a | pend_b | (inWrEn & pend_d);
  assign inReady = rst & ~hazard & (~outValid | outReady);
  assign accept  = inValid & inReady;

  assign hit_a = wbValid && (wbAddr == inRegA);
  assign hit_b = wbValid && (wbAddr == inRegB);

  // Regfile writes at the edge, so same-cycle writeback is forwarded
  always_comb begin
    op_a = hit_a ? wbData : rdDataA;
    op_b = hit_b ? wbData : rdDataB;
`ifdef CPU24_ZERO_REG_EN
    if (inRegA == '0) op_a = '0;
    if (inRegB == '0) op_b = '0;
`endif
  end

  // Output register toward execute behind valid/ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outValid <= 1'b0;
      outOpA   <= '0;
      outOpB   <= '0;
      outRegD  <= '0;
      outWrEn  <= 1'b0;
    end else if (accept) begin
      outValid <= 1'b1;
      outOpA   <= op_a;
      outOpB   <= op_b;
      outRegD  <= inRegD;
      outWrEn  <= inWrEn;
    end else if (outReady) begin
      outValid <= 1'b0;
    end
  end

endmodule
